regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port integer register file for the core: configurable read/write port count, write-enable-qualified bypass, pending-write scoreboard and a handshaked debug (JTAG) access port. After reset it clears the array with a sequential sweep instead of a reset fan-out. It sits between ID (read ports, scoreboard set), MEM/WB (write ports) and the JTAG debug module.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 1, write ports (1..2); higher index has priority
- BYPASS, 1, 1 = same-cycle write-to-read forwarding
- DBG_STARVE, 8, debug wait cycles before dbg_stall_o asserts (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- w_enable_i  in  NUM_WR  per-port write enable
- w_addr_i  in  NUM_WR*ADDR_W  packed write addresses
- w_data_i  in  NUM_WR*DATA_W  packed write data
- r_addr_i  in  NUM_RD*ADDR_W  packed read addresses
- r_data_o  out  NUM_RD*DATA_W  packed read data (combinational)
- r_busy_o  out  NUM_RD  read register has a pending write
- sb_set_i  in  1  mark sb_addr_i pending
- sb_addr_i  in  ADDR_W  scoreboard set address
- init_done_o  out  1  array cleared, block operational
- dbg_req_i  in  1  debug request, held until ack
- dbg_we_i  in  1  1 = write, 0 = read
- dbg_addr_i  in  ADDR_W  debug address
- dbg_wdata_i  in  DATA_W  debug write data
- dbg_ack_o  out  1  one-cycle completion pulse
- dbg_rdata_o  out  DATA_W  debug read data, valid with ack
- dbg_stall_o  out  1  request to core to suppress writes

## Operation
- Reset (rst_n low, any time): FSM → INIT, sweep counter = 0, busy vector = 0, init_done_o/dbg_ack_o/dbg_stall_o = 0, dbg_rdata_o = 0. Array itself not reset.
- INIT: one register zeroed per cycle, index 0..NUM_REGS-1; core writes, sb_set_i, dbg_req_i ignored; r_data_o = 0, r_busy_o = 0. After index NUM_REGS-1 written → IDLE, init_done_o = 1.
- Core write: port enabled and addr ≠ 0 writes at edge. Two ports same address: port 1 wins. Address 0 always reads 0, never busy.
- Read: addr 0 → 0; else if BYPASS and an enabled write port matches (addr ≠ 0) → that port's data (highest index match); else array.
- Scoreboard: busy[a] set by sb_set_i; cleared by enabled core write to a. Set and clear same address same edge → set wins. r_busy_o[k] = busy[r_addr] and not (BYPASS and write to r_addr this cycle). Debug writes do not touch busy.
- Debug FSM states INIT, IDLE, WAIT, DONE:
  - IDLE/WAIT, dbg_req_i = 1, no core write enabled: access executes at this edge (write, or read of pre-edge array value into dbg_rdata_o) → DONE. Address 0 write discarded, read returns 0.
  - IDLE, dbg_req_i = 1, core write enabled → WAIT, wait counter = 1.
  - WAIT, not accepted: counter increments, saturating at DBG_STARVE; dbg_stall_o = 1 once counter = DBG_STARVE, held until acceptance.
  - DONE: dbg_ack_o = 1 for exactly this cycle, dbg_stall_o = 0; → IDLE only when dbg_req_i = 0, else stay (ack not reasserted).
- dbg_rdata_o holds value until next accepted read.

## Timing
- Read and r_busy_o: zero-latency combinational.
- Core write visible in array next cycle; same cycle via bypass.
- Debug: acceptance edge N → dbg_ack_o high cycle N+1. Best-case request-to-ack 1 cycle.
- init_done_o rises NUM_REGS cycles after rst_n deassertion.
- Reset mid-sweep or mid-debug: restart sweep from 0; pending debug request dropped, no ack.

## Structure
- Shared package/define file: DATA_W/ADDR_W defaults, reg-zero and data-zero constants, debug FSM state encodings.
- One sub-module natural: regfile_dbg_ctrl (debug FSM, wait counter, stall, ack, rdata register); array, bypass, scoreboard and init sweep in top.

## Test plan
- Reset release: init_done_o low 32 cycles then high; all r_data_o = 0; pre-seeded array value 0xDEADBEEF in x7 reads 0 after init.
- Write x5 = 0x12345678 with r_addr0 = 5 same cycle → r_data0 = 0x12345678 (BYPASS=1); w_enable_i = 0 with matching address → old value, no forwarding.
- NUM_WR=2, both write x9 (0x1, 0x2) → x9 = 0x2; write x0 = 0xFFFF → x0 reads 0.
- sb_set x3 → r_busy = 1; write x3 same cycle as new sb_set x3 → stays busy; later write x3 alone → busy drops, bypass cycle shows 0.
- Debug read x5 with idle core → ack one cycle later, dbg_rdata_o = 0x12345678; debug write x6 = 0xA5A5 → reads back 0xA5A5.
- Core writes every cycle, dbg_req held → dbg_stall_o after 8 cycles; core drops writes → ack next cycle, stall clears; rst_n pulsed mid-WAIT → no ack, sweep restarts.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared defaults, zero constants and debug FSM encodings for the multi-port register file.
package regfile_mp_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO  = '0;
    localparam logic [DATA_W_DEF-1:0] DATA_ZERO = '0;

    typedef enum logic [1:0] {
        DBG_INIT = 2'd0,
        DBG_IDLE = 2'd1,
        DBG_WAIT = 2'd2,
        DBG_DONE = 2'd3
    } dbg_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Debug (JTAG) access handshake between the debug module (master) and the register file (slave).
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

    logic              dbg_req_i;
    logic              dbg_we_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_wdata_i;
    logic              dbg_ack_o;
    logic [DATA_W-1:0] dbg_rdata_o;
    logic              dbg_stall_o;

    modport master (
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_ack_o, dbg_rdata_o, dbg_stall_o
    );

    modport slave (
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output dbg_ack_o, dbg_rdata_o, dbg_stall_o
    );

endinterface

// File: rtl/regfile_dbg_ctrl.sv
// Debug access controller: init/idle/wait/done FSM, starvation counter, stall request, ack and read-data register.
module regfile_dbg_ctrl
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DBG_STARVE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sweep_last,
    input  logic              i_core_wr,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_init_done,
    output logic              o_ack,
    output logic              o_stall,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_mem_we_c
);

    localparam int unsigned     CNT_W   = $clog2(DBG_STARVE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DBG_STARVE);

    dbg_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_ack, w_ack_nxt;
    logic              r_stall, w_stall_nxt;
    logic              r_init_done, w_init_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= DBG_INIT;
            r_cnt       <= '0;
            r_ack       <= 1'b0;
            r_stall     <= 1'b0;
            r_init_done <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ack       <= w_ack_nxt;
            r_stall     <= w_stall_nxt;
            r_init_done <= w_init_nxt;
            r_rdata     <= w_rdata_nxt;
        end
    end

    // A request is taken only on an edge with no core write enabled.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ack_nxt   = 1'b0;
        w_stall_nxt = r_stall;
        w_init_nxt  = r_init_done;
        w_rdata_nxt = r_rdata;
        w_accept    = 1'b0;
        o_mem_we_c  = 1'b0;

        case (r_state)
            DBG_INIT: begin
                if (i_sweep_last) begin
                    w_state_nxt = DBG_IDLE;
                    w_init_nxt  = 1'b1;
                end
            end
            DBG_IDLE: begin
                if (i_req) begin
                    if (!i_core_wr) begin
                        w_accept = 1'b1;
                    end else begin
                        w_state_nxt = DBG_WAIT;
                        w_cnt_nxt   = CNT_W'(1);
                        w_stall_nxt = (CNT_W'(1) == CNT_MAX);
                    end
                end
            end
            DBG_WAIT: begin
                if (i_req && !i_core_wr) begin
                    w_accept = 1'b1;
                end else begin
                    w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
                    w_stall_nxt = (w_cnt_nxt == CNT_MAX);
                end
            end
            DBG_DONE: begin
                w_stall_nxt = 1'b0;
                if (!i_req) begin
                    w_state_nxt = DBG_IDLE;
                end
            end
            default: w_state_nxt = DBG_INIT;
        endcase

        if (w_accept) begin
            w_state_nxt = DBG_DONE;
            w_ack_nxt   = 1'b1;
            w_stall_nxt = 1'b0;
            if (i_we) begin
                o_mem_we_c = (i_addr != '0);
            end else begin
                w_rdata_nxt = i_rd_data;
            end
        end
    end

    assign o_init_done = r_init_done;
    assign o_ack       = r_ack;
    assign o_stall     = r_stall;
    assign o_rdata     = r_rdata;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with bypass, pending-write scoreboard, sweep clear and debug port.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 1,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned DBG_STARVE = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        w_enable_i,
    input  logic [NUM_WR*ADDR_W-1:0] w_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] w_data_i,
    input  logic [NUM_RD*ADDR_W-1:0] r_addr_i,
    output logic [NUM_RD*DATA_W-1:0] r_data_o,
    output logic [NUM_RD-1:0]        r_busy_o,
    input  logic                     sb_set_i,
    input  logic [ADDR_W-1:0]        sb_addr_i,
    output logic                     init_done_o,
    regfile_mp_if.slave              dbg
);

    localparam int unsigned        NUM_REGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0]  ADDR_ZERO = ADDR_W'(REG_ZERO);
    localparam logic [DATA_W-1:0]  DZERO     = DATA_W'(DATA_ZERO);

    logic [DATA_W-1:0]   r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy, w_busy_nxt;
    logic [ADDR_W-1:0]   r_sweep;

    logic [ADDR_W-1:0]   w_waddr [NUM_WR];
    logic [DATA_W-1:0]   w_wdata [NUM_WR];
    logic [NUM_WR-1:0]   w_wvalid;
    logic [ADDR_W-1:0]   w_raddr [NUM_RD];
    logic [DATA_W-1:0]   w_rval  [NUM_RD];
    logic [NUM_RD-1:0]   w_rhit;

    logic                w_init_done, w_sweep_last, w_core_wr, w_dbg_we;
    logic [DATA_W-1:0]   w_dbg_rd;

    // Unpack write ports; a write is effective only after init and to a non-zero address.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            w_waddr[p]  = w_addr_i[p*ADDR_W +: ADDR_W];
            w_wdata[p]  = w_data_i[p*DATA_W +: DATA_W];
            w_wvalid[p] = w_init_done && w_enable_i[p] && (w_waddr[p] != ADDR_ZERO);
        end
    end

    assign w_core_wr    = |w_enable_i;
    assign w_sweep_last = !w_init_done && (r_sweep == ADDR_W'(NUM_REGS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sweep <= '0;
        end else if (!w_init_done) begin
            r_sweep <= r_sweep + ADDR_W'(1);
        end
    end

    // Array carries no reset; the sweep zeroes it one entry per cycle. Higher write port wins.
    always_ff @(posedge clk) begin
        if (!w_init_done) begin
            r_mem[r_sweep] <= DZERO;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wvalid[p]) begin
                    r_mem[w_waddr[p]] <= w_wdata[p];
                end
            end
            if (w_dbg_we) begin
                r_mem[dbg.dbg_addr_i] <= dbg.dbg_wdata_i;
            end
        end
    end

    // Scoreboard: writes clear, a same-edge set overrides the clear.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_init_done) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wvalid[p]) begin
                    w_busy_nxt[w_waddr[p]] = 1'b0;
                end
            end
            if (sb_set_i && (sb_addr_i != ADDR_ZERO)) begin
                w_busy_nxt[sb_addr_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        r_data_o = '0;
        r_busy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_raddr[k] = r_addr_i[k*ADDR_W +: ADDR_W];
            w_rhit[k]  = 1'b0;
            w_rval[k]  = r_mem[w_raddr[k]];
            for (int p = 0; p < NUM_WR; p++) begin
                if ((BYPASS != 0) && w_wvalid[p] && (w_waddr[p] == w_raddr[k])) begin
                    w_rhit[k] = 1'b1;
                    w_rval[k] = w_wdata[p];
                end
            end
            if (!w_init_done || (w_raddr[k] == ADDR_ZERO)) begin
                w_rval[k] = DZERO;
            end
            r_data_o[k*DATA_W +: DATA_W] = w_rval[k];
            r_busy_o[k] = w_init_done && (w_raddr[k] != ADDR_ZERO)
                          && r_busy[w_raddr[k]] && !w_rhit[k];
        end
    end

    assign w_dbg_rd = (dbg.dbg_addr_i == ADDR_ZERO) ? DZERO : r_mem[dbg.dbg_addr_i];

    regfile_dbg_ctrl #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DBG_STARVE (DBG_STARVE)
    ) u_dbg_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sweep_last (w_sweep_last),
        .i_core_wr    (w_core_wr),
        .i_req        (dbg.dbg_req_i),
        .i_we         (dbg.dbg_we_i),
        .i_addr       (dbg.dbg_addr_i),
        .i_rd_data    (w_dbg_rd),
        .o_init_done  (w_init_done),
        .o_ack        (dbg.dbg_ack_o),
        .o_stall      (dbg.dbg_stall_o),
        .o_rdata      (dbg.dbg_rdata_o),
        .o_mem_we_c   (w_dbg_we)
    );

    assign init_done_o = w_init_done;

endmodule
